// File: rtl/div_seq.sv
// div_seq: sequential restoring shift-subtract divider.
// Unsigned N-bit dividend / divisor taken from the switches at the start edge.
// Each quotient bit takes one SHIFT/SUB pair. Results are registered and held
// until the next completion. A zero divisor finishes early and raises a flag.
module div_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] sw,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_SUB,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    r_q, r_d;        // partial remainder, one bit wider than D
  logic [N-1:0]  q_q, q_d;        // dividend shifting out / quotient shifting in
  logic [N-1:0]  d_q, d_d;        // latched divisor
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    d_ext;
  assign d_ext = {1'b0, d_q};

  // Next-state, datapath and result-register update for the divider HLSM.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d     = '0;
          q_d     = sw[2*N-1:N];
          d_d     = sw[N-1:0];
          count_d = '0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (d_q == '0) begin
          // Q still holds the untouched dividend here.
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // {R,Q} shifted left as one register; a zero enters Q[0].
        r_d     = {r_q[N-1:0], q_q[N-1]};
        q_d     = q_q << 1;
        state_d = S_SUB;
      end

      S_SUB: begin
        if (r_q >= d_ext) begin
          r_d = r_q - d_ext;
          q_d = q_q | N'(1);
        end
        if (count_q == LAST_COUNT) begin
          // Results capture the values this SUB step produces.
          quot_d  = q_d;
          rem_d   = r_d[N-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq (N=4).
// Stimulus pushes expected results (plain integer division) with the cycle at
// which done must appear; a monitor pops and compares on every done pulse and
// checks that results hold steady in between.
module tb_div_seq;

  localparam int N = 4;
  localparam int LAT_NORMAL = 2 * N + 1;  // posedges after the start edge
  localparam int LAT_ZERO   = 1;
  localparam int PERIOD     = 2 * N + 3;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*N-1:0] sw;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;

  div_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sw         (sw),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           due;
    logic [7:0]   opnd;
  } exp_t;

  exp_t sb[$];
  int   compares   = 0;
  int   mismatches = 0;
  int   cyc        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Reference model: plain integer division, with the zero-divisor rule.
  task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b, input int start_edge);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.due = start_edge + LAT_ZERO;
    end else begin
      e.q   = N'(int'(a) / int'(b));
      e.r   = N'(int'(a) % int'(b));
      e.dbz = 1'b0;
      e.due = start_edge + LAT_NORMAL;
    end
    e.opnd = {a, b};
    sb.push_back(e);
  endtask

  // Monitor: compare on done, otherwise check the held outputs.
  initial begin
    exp_t         e;
    logic [N-1:0] h_q;
    logic [N-1:0] h_r;
    logic         h_dbz;
    h_q = '0; h_r = '0; h_dbz = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_q = '0; h_r = '0; h_dbz = 1'b0;
      end else if (done) begin
        if (sb.size() == 0) begin
          compares++; mismatches++;
          $display("FAIL unexpected_done cyc=%0d q=%0d r=%0d dbz=%0b (no result was due)",
                   cyc, quotient, remainder, div_by_zero);
        end else begin
          e = sb.pop_front();
          compares++;
          if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            mismatches++;
            $display("FAIL result sw=%h got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                     e.opnd, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
          end else begin
            $display("sw=%h -> q=%0d r=%0d dbz=%0b at cyc %0d",
                     e.opnd, quotient, remainder, div_by_zero, cyc);
          end
          compares++;
          if (cyc != e.due) begin
            mismatches++;
            $display("FAIL latency sw=%h done at cyc=%0d expected cyc=%0d", e.opnd, cyc, e.due);
          end
          h_q = e.q; h_r = e.r; h_dbz = e.dbz;
        end
      end else begin
        compares++;
        if (quotient !== h_q || remainder !== h_r || div_by_zero !== h_dbz) begin
          mismatches++;
          $display("FAIL hold cyc=%0d got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                   cyc, quotient, remainder, div_by_zero, h_q, h_r, h_dbz);
        end
      end
    end
  end

  task automatic check_reset(input string name);
    compares++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
        quotient !== '0 || remainder !== '0) begin
      mismatches++;
      $display("FAIL %s busy=%0b done=%0b dbz=%0b q=%0d r=%0d expected all zero",
               name, busy, done, div_by_zero, quotient, remainder);
    end else begin
      $display("%s: outputs cleared", name);
    end
  endtask

  // Drive one start pulse; the start edge is the next posedge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit expect_it);
    @(negedge clk);
    sw    = {a, b};
    start = 1'b1;
    if (expect_it) push_exp(a, b, cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for busy to drop, optionally scrambling the switches meanwhile.
  task automatic wait_idle(input bit scramble);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      if (scramble) sw = 8'($urandom);
    end
    compares++; mismatches++;
    $display("FAIL idle_timeout busy still high after 100 cycles at cyc=%0d", cyc);
  endtask

  initial begin
    int s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    rst = 1'b1; start = 1'b0; sw = '0;
    repeat (2) @(negedge clk);
    check_reset("reset_init");
    rst = 1'b0;

    // Basic operand patterns.
    issue(4'hD, 4'h3, 1'b1); wait_idle(1'b0);
    issue(4'hF, 4'h1, 1'b1); wait_idle(1'b0);
    issue(4'h3, 4'h7, 1'b1); wait_idle(1'b0);
    issue(4'hF, 4'hF, 1'b1); wait_idle(1'b0);

    // Reset pulse while idle with nonzero held results.
    #1 rst = 1'b1;
    #1 check_reset("reset_idle");
    @(negedge clk); @(posedge clk); #2 rst = 1'b0;

    // Zero divisor, then a normal run clears the flag.
    issue(4'h9, 4'h0, 1'b1); wait_idle(1'b0);
    issue(4'h4, 4'h2, 1'b1); wait_idle(1'b0);

    // Start re-pulsed with new switches while busy is ignored.
    issue(4'hD, 4'h3, 1'b1);
    repeat (2) @(negedge clk);
    sw = 8'h21; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b1);

    // Asynchronous reset in the middle of a run aborts it.
    issue(4'hD, 4'h3, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset("reset_midrun");
    @(negedge clk); @(posedge clk); #2 rst = 1'b0;
    issue(4'hE, 4'h4, 1'b1); wait_idle(1'b0);

    // Start held high: back-to-back operations every PERIOD cycles.
    @(negedge clk);
    s = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      while (cyc + 1 < s + PERIOD * k) @(negedge clk);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(1, 15));
      sw = {a, b};
      start = 1'b1;
      push_exp(a, b, s + PERIOD * k);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle(1'b0);

    // Randomized operands, occasional zero divisor, noisy switches while busy.
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(a, b, 1'b1);
      wait_idle(1'b1);
    end

    repeat (30) @(negedge clk);
    compares++;
    if (sb.size() != 0) begin
      mismatches++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
